// File: rtl/empty_acc_gen.sv
`default_nettype none
// ============================================================================
// Module      : empty_acc_gen
// Description : Issues MAX_REQS one-cycle add requests of STEP*(k+1), one per
//               PERIOD cycles, to a parent accumulator. Optional checker
//               (EMPTY_ACC_CHECK_EN) shadows the sum and flags divergence.
// Revision    : 1.0 - initial release
// ============================================================================
module empty_acc_gen #(
    parameter int unsigned PERIOD   = 4,
    parameter logic [31:0] STEP     = 32'd1,
    parameter int unsigned MAX_REQS = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [63:0] cycles,
    input  logic [31:0] accumulator,
    output logic        valid,
    output logic [31:0] value
`ifdef EMPTY_ACC_CHECK_EN
    ,
    output logic        mismatch
`endif
);

    localparam int unsigned             c_phase_w    = $clog2(PERIOD);
    localparam logic [c_phase_w-1:0]    c_phase_last = c_phase_w'(PERIOD - 1);
    localparam logic [15:0]             c_max_reqs   = 16'(MAX_REQS);

    logic [15:0] r_k;
    logic        r_valid;
    logic [31:0] r_value;
    logic        w_issue;
    logic        w_unused_cycles;

    assign w_issue         = (cycles[c_phase_w-1:0] == c_phase_last) && (r_k < c_max_reqs);
    assign w_unused_cycles = ^cycles[63:c_phase_w];

    // value always holds STEP*k, so the next addend is just value+STEP
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_k     <= 16'd0;
            r_valid <= 1'b0;
            r_value <= 32'd0;
        end else begin
            r_valid <= w_issue;
            if (w_issue) begin
                r_k     <= r_k + 16'd1;
                r_value <= r_value + STEP;
            end
        end
    end

    assign valid = r_valid;
    assign value = r_value;

`ifdef EMPTY_ACC_CHECK_EN
    logic [31:0] r_shadow;
    logic        r_armed;
    logic        r_mismatch;

    // The first edge after release only arms the comparator
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow   <= 32'd0;
            r_armed    <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (r_valid) begin
                r_shadow <= r_shadow + r_value;
            end
            if (r_armed && (accumulator != r_shadow)) begin
                r_mismatch <= 1'b1;
            end
        end
    end

    assign mismatch = r_mismatch;
`else
    logic w_unused_acc;
    assign w_unused_acc = ^accumulator;
`endif

endmodule
`default_nettype wire

// File: tb/tb_empty_acc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_empty_acc_gen
// Description : Self-checking bench for empty_acc_gen (three configurations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_empty_acc_gen;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] cycles = 64'd0;
    logic        corrupt = 1'b0;
    logic [31:0] acc [3];
    logic        v   [3];
    logic [31:0] val [3];
    logic        mm  [3];
    logic [31:0] w_acc0_in;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    assign w_acc0_in = corrupt ? 32'd99 : acc[0];

    // Parent: adds value on every edge where valid is high
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) acc[i] <= 32'd0;
        end else begin
            for (int i = 0; i < 3; i++) if (v[i]) acc[i] <= acc[i] + val[i];
        end
    end

    empty_acc_gen #(.PERIOD(4), .STEP(32'd1), .MAX_REQS(3)) u0 (
        .clock(clock), .reset_n(reset_n), .cycles(cycles), .accumulator(w_acc0_in),
        .valid(v[0]), .value(val[0])
`ifdef EMPTY_ACC_CHECK_EN
        , .mismatch(mm[0])
`endif
    );

    empty_acc_gen #(.PERIOD(8), .STEP(32'h8000_0000), .MAX_REQS(2)) u1 (
        .clock(clock), .reset_n(reset_n), .cycles(cycles), .accumulator(acc[1]),
        .valid(v[1]), .value(val[1])
`ifdef EMPTY_ACC_CHECK_EN
        , .mismatch(mm[1])
`endif
    );

    empty_acc_gen #(.PERIOD(16), .STEP(32'h1234_5679), .MAX_REQS(16)) u2 (
        .clock(clock), .reset_n(reset_n), .cycles(cycles), .accumulator(acc[2]),
        .valid(v[2]), .value(val[2])
`ifdef EMPTY_ACC_CHECK_EN
        , .mismatch(mm[2])
`endif
    );

`ifndef EMPTY_ACC_CHECK_EN
    initial for (int i = 0; i < 3; i++) mm[i] = 1'b0;
`endif

    function automatic int unsigned per_of(int i);
        return (i == 0) ? 4 : (i == 1) ? 8 : 16;
    endfunction
    function automatic logic [31:0] step_of(int i);
        return (i == 0) ? 32'd1 : (i == 1) ? 32'h8000_0000 : 32'h1234_5679;
    endfunction
    function automatic int unsigned max_of(int i);
        return (i == 0) ? 3 : (i == 1) ? 2 : 16;
    endfunction

    // Sum of the first n addends: STEP*n*(n+1)/2 mod 2^32
    function automatic logic [31:0] sum_of(int i, int unsigned n);
        longint unsigned t;
        t = (longint'(n) * longint'(n + 1)) / 2;
        return 32'(longint'(step_of(i)) * t);
    endfunction

    // Reference model state
    int unsigned mk  [3];
    logic        ev  [3];
    logic [31:0] eval[3];
    logic        em  [3];
    logic        arm [3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mk[i] = 0; ev[i] = 1'b0; eval[i] = 32'd0; em[i] = 1'b0; arm[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [31:0] acc_in;
        if (!reset_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            acc_in = (i == 0) ? w_acc0_in : acc[i];
            if (arm[i] && acc_in != sum_of(i, mk[i] - (ev[i] ? 1 : 0))) em[i] = 1'b1;
            arm[i] = 1'b1;
            if ((cycles % per_of(i)) == per_of(i) - 1 && mk[i] < max_of(i)) begin
                mk[i]++;
                ev[i]   = 1'b1;
                eval[i] = 32'(longint'(step_of(i)) * longint'(mk[i]));
            end else begin
                ev[i] = 1'b0;
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycles=%0h t=%0t)", name, act, exp, cycles, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d.valid", i), {31'd0, v[i]}, {31'd0, ev[i]});
            chk($sformatf("u%0d.value", i), val[i], eval[i]);
`ifdef EMPTY_ACC_CHECK_EN
            chk($sformatf("u%0d.mismatch", i), {31'd0, mm[i]}, {31'd0, em[i]});
`endif
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        tick();
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [63:0] cyc;
        logic        exp_valid;
        logic [31:0] exp_value;
    } vec_t;

    vec_t tbl [16];

    initial begin
        tbl[0]  = '{64'd0,  1'b0, 32'd0};
        tbl[1]  = '{64'd1,  1'b0, 32'd0};
        tbl[2]  = '{64'd2,  1'b0, 32'd0};
        tbl[3]  = '{64'd3,  1'b1, 32'd1};
        tbl[4]  = '{64'd4,  1'b0, 32'd1};
        tbl[5]  = '{64'd5,  1'b0, 32'd1};
        tbl[6]  = '{64'd6,  1'b0, 32'd1};
        tbl[7]  = '{64'd7,  1'b1, 32'd2};
        tbl[8]  = '{64'd8,  1'b0, 32'd2};
        tbl[9]  = '{64'd9,  1'b0, 32'd2};
        tbl[10] = '{64'd10, 1'b0, 32'd2};
        tbl[11] = '{64'd11, 1'b1, 32'd3};
        tbl[12] = '{64'd12, 1'b0, 32'd3};
        tbl[13] = '{64'd15, 1'b0, 32'd3};
        tbl[14] = '{64'd19, 1'b0, 32'd3};
        tbl[15] = '{64'd23, 1'b0, 32'd3};

        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;

        // Basic issue and idle for u0, wrap for u1
        for (int i = 0; i < 16; i++) begin
            cycles = tbl[i].cyc;
            tick();
            chk($sformatf("tbl[%0d].valid", i), {31'd0, v[0]}, {31'd0, tbl[i].exp_valid});
            chk($sformatf("tbl[%0d].value", i), val[0], tbl[i].exp_value);
        end
        chk("idle_acc_sum", acc[0], 32'd6);
        chk("wrap_acc_sum", acc[1], 32'h8000_0000);
        for (int c = 27; c <= 43; c += 4) begin
            cycles = 64'(c);
            tick();
            chk("idle_valid_low", {31'd0, v[0]}, 32'd0);
        end

`ifdef EMPTY_ACC_CHECK_EN
        chk("wrap_no_mismatch", {31'd0, mm[1]}, 32'd0);
        corrupt = 1'b1;
        cycles  = 64'd44;
        tick();
        corrupt = 1'b0;
        chk("chk_flag_set", {31'd0, mm[0]}, 32'd1);
        repeat (3) begin
            cycles++;
            tick();
        end
        chk("chk_flag_sticky", {31'd0, mm[0]}, 32'd1);
`endif

        // Reset asserted while a request is in flight
        reset_pulse();
        for (int c = 0; c < 4; c++) begin
            cycles = 64'(c);
            tick();
        end
        chk("pre_rst_valid", {31'd0, v[0]}, 32'd1);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", {31'd0, v[0]}, 32'd0);
        chk("async_rst_value", val[0], 32'd0);
        chk("async_rst_mismatch", {31'd0, mm[0]}, 32'd0);
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycles = 64'(c);
            tick();
        end
        chk("post_rst_valid", {31'd0, v[0]}, 32'd1);
        chk("post_rst_value", val[0], 32'd1);

        // cycles wrap-around
        reset_pulse();
        cycles = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        for (int i = 0; i < 5; i++) begin
            cycles = cycles + 64'd1;
            tick();
        end
        chk("cwrap_valid_at3", {31'd0, v[0]}, 32'd1);
        chk("cwrap_value_at3", val[0], 32'd2);

        // Randomized run with occasional resets and jumps
        cycles = {$urandom, $urandom};
        for (int n = 0; n < 900; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                reset_pulse();
            end else begin
                if ($urandom_range(0, 19) == 0) cycles = {$urandom, $urandom};
                else cycles = cycles + 64'd1;
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
